// File: rtl/elastic_read_ctrl.sv
// elastic_read_ctrl: read side of the receive elastic buffer.
// Walks the buffer one symbol per cycle and returns a Gray read pointer to
// the threshold monitor. Fill level is centred by repeating or dropping the
// first SKP of an incoming SKP ordered set. Define ELASTIC_STATS_EN to add
// saturating add/delete event counters as extra output ports.
module elastic_read_ctrl #(
  parameter int                    BUFFER_DEPTH = 16,
  parameter int                    DATA_WIDTH   = 9,
  parameter logic [DATA_WIDTH-1:0] COM_SYM      = 9'h1BC,
  parameter logic [DATA_WIDTH-1:0] SKP_SYM      = 9'h11C,
  localparam int                   ADDR_W       = $clog2(BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic                  add_req,
  input  logic                  delete_req,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [ADDR_W:0]       gray_read_pointer,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  skp_added,
  output logic                  skp_deleted
`ifdef ELASTIC_STATS_EN
  ,
  output logic [7:0]            add_count,
  output logic [7:0]            delete_count
`endif
);

  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_COM_SEEN = 2'd1;
  localparam logic [1:0] ST_SKP_RUN  = 2'd2;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]       bin_ptr;
  logic [1:0]            state;
  logic                  add_q;
  logic                  del_q;

  logic [ADDR_W:0]       ptr_nxt;
  logic [DATA_WIDTH-1:0] dout_nxt;
  logic                  valid_nxt;
  logic                  add_pulse;
  logic                  del_pulse;
  logic [1:0]            state_nxt;
  logic                  is_com;
  logic                  is_skp;

  assign rd_addr = bin_ptr[ADDR_W-1:0];
  assign is_com  = (rd_data_in == COM_SYM);
  assign is_skp  = (rd_data_in == SKP_SYM);

  // Register the monitor requests; contradictory requests cancel each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_q <= 1'b0;
      del_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      add_q <= add_req & ~delete_req;
      del_q <= delete_req & ~add_req;
    end
  end

  // Next-state decode: normal read by default, SKP action on the first SKP after COM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    ptr_nxt   = bin_ptr;
    dout_nxt  = data_out;
    valid_nxt = 1'b0;
    add_pulse = 1'b0;
    del_pulse = 1'b0;
    state_nxt = state;
    if (read_en) begin
      ptr_nxt   = bin_ptr + PTR_ONE;
      dout_nxt  = rd_data_in;
      valid_nxt = 1'b1;
      case (state)
        ST_NORMAL: begin
          if (is_com) state_nxt = ST_COM_SEEN;
        end
        ST_COM_SEEN: begin
          if (is_skp) begin
            state_nxt = ST_SKP_RUN;
            if (del_q) begin
              // Skip this SKP: advance the pointer but emit nothing.
              dout_nxt  = data_out;
              valid_nxt = 1'b0;
              del_pulse = 1'b1;
            end else if (add_q) begin
              // Emit SKP now and re-read the same entry next cycle.
              ptr_nxt   = bin_ptr;
              dout_nxt  = SKP_SYM;
              add_pulse = 1'b1;
            end
          end else if (!is_com) begin
            state_nxt = ST_NORMAL;
          end
        end
        ST_SKP_RUN: begin
          if (is_com)       state_nxt = ST_COM_SEEN;
          else if (!is_skp) state_nxt = ST_NORMAL;
        end
        default: state_nxt = ST_NORMAL;
      endcase
    end
  end

  // Pointer, Gray pointer, output stage and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_ptr           <= '0;
      gray_read_pointer <= '0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      skp_added         <= 1'b0;
      skp_deleted       <= 1'b0;
      state             <= ST_NORMAL;
    end else begin
      bin_ptr           <= ptr_nxt;
      gray_read_pointer <= ptr_nxt ^ (ptr_nxt >> 1);
      data_out          <= dout_nxt;
      data_valid        <= valid_nxt;
      skp_added         <= add_pulse;
      skp_deleted       <= del_pulse;
      state             <= state_nxt;
    end
  end

`ifdef ELASTIC_STATS_EN
  // Saturating event counters driven by the registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_count    <= 8'd0;
      delete_count <= 8'd0;
    end else begin
      if (skp_added && (add_count != 8'hFF))      add_count    <= add_count + 8'd1;
      if (skp_deleted && (delete_count != 8'hFF)) delete_count <= delete_count + 8'd1;
    end
  end
`endif

endmodule
